// File: rtl/inst_fetch.sv
// Instruction fetch stage: word PC, single-outstanding req/ack imem reads, PC-tagged
// prefetch FIFO and a valid/ready stream to decode, with branch/jump redirect flush.
module inst_fetch #(
   parameter int          ADDR_W     = 16,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_redirect,
   input  logic [31:0]       i_redirect_pc,
   output logic              o_imem_req,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic              i_imem_ack,
   input  logic [31:0]       i_imem_rdata,
   output logic              o_inst_valid,
   input  logic              i_inst_ready,
   output logic [31:0]       o_inst_data,
   output logic [31:0]       o_inst_pc
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_n;
   logic [31:0]       r_pc;
   logic [31:0]       w_pc_n;
   logic              r_req;
   logic              w_req_n;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_n;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_cnt_pop;
   logic [31:0]       r_mem_data [FIFO_DEPTH];
   logic [31:0]       r_mem_pc   [FIFO_DEPTH];
   logic              w_ack;
   logic              w_push;
   logic              w_pop;
   logic              w_flush;
   logic              w_valid;

   // Head is hidden during a redirect so a stale word is never consumed.
   assign w_valid   = (r_count != {CNT_W{1'b0}}) & ~i_redirect;
   assign w_pop     = w_valid & i_inst_ready;
   assign w_ack     = r_req & i_imem_ack;
   assign w_cnt_pop = r_count - CNT_W'(w_pop);

   assign o_inst_valid = w_valid;
   assign o_inst_data  = w_valid ? r_mem_data[r_rd_ptr] : NOP;
   assign o_inst_pc    = w_valid ? r_mem_pc[r_rd_ptr] : 32'h0000_0000;
   assign o_imem_req   = r_req;
   assign o_imem_addr  = r_addr;

   // Next-state, next-PC and request/credit decisions.
   always_comb begin
      w_state_n = r_state;
      w_pc_n    = r_pc;
      w_req_n   = r_req;
      w_addr_n  = r_addr;
      w_push    = 1'b0;
      w_flush   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_redirect) begin
               w_pc_n = i_redirect_pc;
            end else begin
               w_pc_n = r_pc;
            end
            if (i_start) begin
               w_state_n = S_RUN;
               w_req_n   = 1'b1;
               w_addr_n  = w_pc_n[ADDR_W-1:0];
            end else begin
               w_req_n   = 1'b0;
            end
         end
         S_RUN: begin
            if (i_redirect) begin
               w_flush = 1'b1;
               w_pc_n  = i_redirect_pc;
               if (r_req && !i_imem_ack) begin
                  // The pending read cannot be cancelled; wait it out in DRAIN.
                  w_state_n = S_DRAIN;
               end else begin
                  w_req_n  = 1'b1;
                  w_addr_n = i_redirect_pc[ADDR_W-1:0];
               end
            end else if (w_ack) begin
               w_push   = 1'b1;
               w_pc_n   = r_pc + 32'd1;
               w_req_n  = (w_cnt_pop + CNT_W'(1)) < DEPTH_C;
               w_addr_n = w_pc_n[ADDR_W-1:0];
            end else if (!r_req) begin
               w_req_n  = w_cnt_pop < DEPTH_C;
               w_addr_n = r_pc[ADDR_W-1:0];
            end else begin
               w_req_n  = 1'b1;
            end
         end
         S_DRAIN: begin
            if (i_redirect) begin
               w_flush = 1'b1;
               w_pc_n  = i_redirect_pc;
            end else begin
               w_pc_n  = r_pc;
            end
            if (w_ack) begin
               w_state_n = S_RUN;
               w_req_n   = 1'b1;
               w_addr_n  = w_pc_n[ADDR_W-1:0];
            end else begin
               w_req_n   = 1'b1;
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_req_n   = 1'b0;
         end
      endcase
   end

   // FSM, fetch PC and imem request registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_req   <= 1'b0;
         r_addr  <= {ADDR_W{1'b0}};
      end else begin
         r_state <= w_state_n;
         r_pc    <= w_pc_n;
         r_req   <= w_req_n;
         r_addr  <= w_addr_n;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else if (w_flush) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // FIFO storage; contents are qualified by r_count so they need no reset.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= i_imem_rdata;
         r_mem_pc[r_wr_ptr]   <= r_pc;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: behavioural imem with programmable ack latency
// and a scoreboard of expected PCs popped on every decode handshake.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   int          n_cmp = 0;
   int          n_err = 0;
   int          ack_delay = 0;
   int          wait_cnt;
   logic [31:0] exp_q [$];

   inst_fetch #(.ADDR_W(16), .FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_redirect(redirect),
      .i_redirect_pc(redirect_pc), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
      .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata), .o_inst_valid(inst_valid),
      .i_inst_ready(inst_ready), .o_inst_data(inst_data), .o_inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   // Instruction memory: ack after ack_delay wait cycles, data = word address + 0x100.
   assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
   assign imem_rdata = {16'h0000, imem_addr} + 32'h0000_0100;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_cnt <= 0;
      else if (!imem_req || imem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one cycle, popping and comparing the scoreboard on a decode handshake.
   task automatic sb_cycle();
      logic [31:0] e;
      @(negedge clk);
      if (inst_valid && inst_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_extra: got pc=%h data=%h, expected no output", inst_pc, inst_data);
         end else begin
            e = exp_q.pop_front();
            if (inst_pc !== e || inst_data !== ({16'h0000, e[15:0]} + 32'h0000_0100)) begin
               n_err++;
               $display("FAIL sb_word: got pc=%h data=%h, expected pc=%h data=%h",
                        inst_pc, inst_data, e, {16'h0000, e[15:0]} + 32'h0000_0100);
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      inst_ready = 1'b1; ack_delay = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      inst_ready = 1'b1; ack_delay = 0;
      #2;
      n_cmp++;
      if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || inst_valid !== 1'b0 ||
          inst_data !== 32'h0000_0013 || inst_pc !== 32'h0) begin
         n_err++;
         $display("FAIL reset_vals: req=%b addr=%h valid=%b data=%h pc=%h, expected 0 0 0 00000013 0",
                  imem_req, imem_addr, inst_valid, inst_data, inst_pc);
      end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_stream();
      do_reset();
      start = 1'b1;
      for (int i = 0; i < 20; i++) exp_q.push_back(32'(i));
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stream_c0: req=%b valid=%b, expected 0 0", imem_req, inst_valid);
      end
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || inst_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stream_c1: req=%b addr=%h valid=%b, expected 1 0000 0", imem_req, imem_addr, inst_valid);
      end
      @(posedge clk); #1;
      repeat (20) sb_cycle();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL stream_rate: %0d words still pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      int nacks = 0;
      do_reset();
      inst_ready = 1'b0;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imem_req && imem_ack) nacks++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (nacks != 4 || imem_req !== 1'b0) begin
         n_err++;
         $display("FAIL bp_fill: pushes=%0d req=%b, expected 4 0", nacks, imem_req);
      end
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
         n_err++;
         $display("FAIL bp_head: valid=%b pc=%h, expected 1 00000000", inst_valid, inst_pc);
      end
      inst_ready = 1'b1;
      for (int i = 0; i < 10; i++) exp_q.push_back(32'(i));
      repeat (10) sb_cycle();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL bp_resume: %0d words still pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_redirect_idle();
      do_reset();
      inst_ready = 1'b0;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      redirect = 1'b1; redirect_pc = 32'h0000_0040;
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b0) begin
         n_err++;
         $display("FAIL redir_mask: valid=%b, expected 0", inst_valid);
      end
      @(posedge clk); #1 redirect = 1'b0; inst_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || inst_valid !== 1'b0) begin
         n_err++;
         $display("FAIL redir_addr: req=%b addr=%h valid=%b, expected 1 0040 0", imem_req, imem_addr, inst_valid);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h40 + 32'(i));
      repeat (8) sb_cycle();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL redir_seq: %0d words still pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_redirect_drain();
      int i;
      do_reset();
      ack_delay = 3;
      start = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h1);
      sb_cycle();
      start = 1'b0;
      for (i = 0; i < 60 && !(imem_req && imem_addr == 16'h0002 && wait_cnt == 1); i++) sb_cycle();
      n_cmp++;
      if (i >= 60 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_setup: iters=%0d pending=%0d, expected <60 0", i, exp_q.size());
      end
      redirect = 1'b1; redirect_pc = 32'h0000_0080;
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
         n_err++;
         $display("FAIL drain_enter: valid=%b req=%b addr=%h, expected 0 1 0002", inst_valid, imem_req, imem_addr);
      end
      @(posedge clk); #1 redirect = 1'b0;
      for (i = 0; i < 10 && !imem_ack; i++) begin
         @(negedge clk);
         n_cmp++;
         if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_hold: req=%b addr=%h valid=%b, expected 1 0002 0", imem_req, imem_addr, inst_valid);
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (!imem_ack || imem_addr !== 16'h0002) begin
         n_err++;
         $display("FAIL drain_ack: ack=%b addr=%h, expected 1 0002", imem_ack, imem_addr);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0080 || inst_valid !== 1'b0) begin
         n_err++;
         $display("FAIL drain_exit: req=%b addr=%h valid=%b, expected 1 0080 0", imem_req, imem_addr, inst_valid);
      end
      exp_q.push_back(32'h80); exp_q.push_back(32'h81);
      repeat (10) sb_cycle();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_seq: %0d words still pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_redirect_ack();
      int i;
      do_reset();
      start = 1'b1;
      for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
      sb_cycle();
      start = 1'b0;
      for (i = 0; i < 30 && !(imem_req && imem_addr == 16'h0005); i++) sb_cycle();
      n_cmp++;
      if (i >= 30 || !imem_ack || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL rack_setup: iters=%0d ack=%b pending=%0d, expected <30 1 0", i, imem_ack, exp_q.size());
      end
      redirect = 1'b1; redirect_pc = 32'h0000_0020;
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rack_mask: valid=%b, expected 0", inst_valid);
      end
      @(posedge clk); #1 redirect = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0020 || inst_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rack_addr: req=%b addr=%h valid=%b, expected 1 0020 0", imem_req, imem_addr, inst_valid);
      end
      @(posedge clk); #1;
      for (int k = 0; k < 6; k++) exp_q.push_back(32'h20 + 32'(k));
      repeat (6) sb_cycle();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL rack_seq: %0d words still pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_wrap();
      do_reset();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         n_err++;
         $display("FAIL wrap_idle: req=%b valid=%b, expected 0 0", imem_req, inst_valid);
      end
      @(posedge clk); #1 redirect = 1'b0; start = 1'b1;
      exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF);
      exp_q.push_back(32'h0); exp_q.push_back(32'h1);
      sb_cycle();
      start = 1'b0;
      repeat (5) sb_cycle();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL wrap_seq: %0d words still pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      inst_ready = 1'b0;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_req !== 1'b1) begin
         n_err++;
         $display("FAIL rmid_pre: valid=%b pc=%h req=%b, expected 1 00000000 1", inst_valid, inst_pc, imem_req);
      end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || inst_valid !== 1'b0 ||
          inst_data !== 32'h0000_0013 || inst_pc !== 32'h0) begin
         n_err++;
         $display("FAIL rmid_vals: req=%b addr=%h valid=%b data=%h pc=%h, expected 0 0 0 00000013 0",
                  imem_req, imem_addr, inst_valid, inst_data, inst_pc);
      end
      @(posedge clk); #1 rst_n = 1'b1; inst_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++;
         if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_idle: cycle %0d req=%b valid=%b, expected 0 0", k, imem_req, inst_valid);
         end
         @(posedge clk); #1;
      end
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
         n_err++;
         $display("FAIL rmid_restart: req=%b addr=%h, expected 1 0000", imem_req, imem_addr);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_idle();
      test_redirect_drain();
      test_redirect_ack();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
